imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs LEN words (little-endian) into the instruction
// memory, verifies an XOR checksum, and releases the CPU from reset only on success.
module imem_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [15:0]       DEPTH_LEN = 16'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_W    = ADDR_W'(BASE_ADDR);

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic [15:0]       len_full;

  assign accept   = byte_valid & byte_ready_q;
  assign len_full = {byte_in, len_lo_q};

  always_comb begin
    // NOTE: every _d gets a default here so no path leaves a signal unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    lane_d       = lane_q;
    word_d       = word_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          word_idx_d = '0;
          lane_d     = '0;
          csum_d     = '0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_lo_d = byte_in;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_full;
          if (len_full > DEPTH_LEN)   state_d = S_ERR;
          else if (len_full == 16'd0) state_d = S_CSUM;
          else                        state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ byte_in;
          lane_d = lane_q + 2'd1;
          // Lanes 0..2 shift in from the top so b0 ends up in the low byte.
          word_d = {byte_in, word_q[23:8]};
          if (lane_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = BASE_W + ADDR_W'(word_idx_q);
            imem_wdata_d = {byte_in, word_q};
            word_idx_d   = word_idx_q + 16'd1;
            if (word_idx_q == len_q - 16'd1) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies.
    byte_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                   (state_d == S_DATA) || (state_d == S_CSUM);
    busy_d       = byte_ready_d;
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    cpu_rst_d    = (state_d != S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed images from the test plan plus random
// images, compared against an image-level model of expected writes and outcome.
module tb_imem_loader;

  localparam int DEPTH     = 64;
  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  img_q[$];
  logic [39:0] wr_q[$];
  logic [39:0] exp_q[$];
  bit          exp_done;
  int          n_send;
  bit          gap_phase;

  // Every write strobe is visible for exactly one negedge.
  always @(negedge clk) if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});

  // Image-level model: expected writes, outcome and number of bytes the loader takes.
  task automatic build_model();
    int len;
    logic [7:0] cs;
    exp_q.delete();
    len = int'({img_q[1], img_q[0]});
    if (len > DEPTH) begin
      exp_done = 1'b0;
      n_send   = 2;
    end else begin
      cs = 8'h00;
      for (int w = 0; w < len; w++) begin
        exp_q.push_back({8'((BASE_ADDR + w) % 256),
                         img_q[2+4*w+3], img_q[2+4*w+2], img_q[2+4*w+1], img_q[2+4*w]});
        for (int k = 0; k < 4; k++) cs = cs ^ img_q[2+4*w+k];
      end
      exp_done = (img_q[2+4*len] == cs);
      n_send   = 3 + 4*len;
    end
  endtask

  task automatic make_random_image(input int len, input bit corrupt);
    logic [7:0] cs, b;
    img_q.delete();
    img_q.push_back(len[7:0]);
    img_q.push_back(len[15:8]);
    if (len <= DEPTH) begin
      cs = 8'h00;
      for (int i = 0; i < 4*len; i++) begin
        b = 8'($urandom);
        img_q.push_back(b);
        cs = cs ^ b;
      end
      img_q.push_back(corrupt ? (cs ^ 8'($urandom_range(1, 255))) : cs);
    end
  endtask

  task automatic load_good_image();
    img_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps.
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit sent = 1'b0;
    bit go;
    for (int i = 0; i < 200 && !sent; i++) begin
      @(negedge clk);
      if (mode == 0) go = 1'b1;
      else if (mode == 1) begin
        gap_phase = ~gap_phase;
        go = gap_phase;
      end else go = 1'($urandom_range(0, 1));
      byte_valid = go;
      byte_in    = go ? b : 8'($urandom);
      if (go && byte_ready) begin
        @(posedge clk);
        sent = 1'b1;
      end
    end
    if (!sent) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte_timeout: byte %02h not accepted within 200 cycles, byte_ready=%b", b, byte_ready);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_image(input string name, input int mode);
    build_model();
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < n_send; i++) send_byte(img_q[i], mode);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got addr=%02h data=%08h expected addr=%02h data=%08h",
                 name, i, wr_q[i][39:32], wr_q[i][31:0], exp_q[i][39:32], exp_q[i][31:0]);
      end
    end
    n_checks++;
    if ({done, error, cpu_rst, busy, byte_ready} !== {exp_done, !exp_done, !exp_done, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s status: got done=%b error=%b cpu_rst=%b busy=%b ready=%b expected %b %b %b 0 0",
               name, done, error, cpu_rst, busy, byte_ready, exp_done, !exp_done, !exp_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cpu_rst, byte_ready, busy, done, error, imem_we} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outputs: got cpu_rst=%b ready=%b busy=%b done=%b error=%b we=%b expected 1 0 0 0 0 0",
               cpu_rst, byte_ready, busy, done, error, imem_we);
    end
    n_checks++;
    if ({imem_addr, imem_wdata} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got addr=%02h data=%08h expected 00 00000000", imem_addr, imem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_good_image();
    load_good_image();
    run_image("good_image", 0);
    n_checks++;
    if (wr_q.size() != 2 || wr_q[0] !== {8'h00, 32'h00500093} || wr_q[1] !== {8'h01, 32'h00A00113}) begin
      n_fail++;
      $display("FAIL good_image_literal: got %0d writes, expected 00:00500093 and 01:00A00113", wr_q.size());
    end
  endtask

  task automatic test_throttled();
    load_good_image();
    gap_phase = 1'b0;
    run_image("throttled", 1);
  endtask

  task automatic test_bad_csum();
    load_good_image();
    img_q[10] = 8'h70;
    run_image("bad_csum", 0);
  endtask

  task automatic test_overflow();
    wr_q.delete();
    pulse_start();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    n_checks++;
    if ({error, done, busy, byte_ready, cpu_rst} !== 5'b10001) begin
      n_fail++;
      $display("FAIL overflow_status: got error=%b done=%b busy=%b ready=%b cpu_rst=%b expected 1 0 0 0 1",
               error, done, busy, byte_ready, cpu_rst);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL overflow_writes: got %0d writes expected 0", wr_q.size());
    end
  endtask

  task automatic test_len_depth();
    make_random_image(DEPTH, 1'b0);
    run_image("len_depth", 2);
  endtask

  task automatic test_reset_mid_load();
    load_good_image();
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(img_q[i], 0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {8'h00, 32'h00500093}) begin
      n_fail++;
      $display("FAIL mid_reset_writes: got %0d writes expected exactly 00:00500093", wr_q.size());
    end
    n_checks++;
    if ({cpu_rst, busy, byte_ready, done, error} !== 5'b10000) begin
      n_fail++;
      $display("FAIL mid_reset_status: got cpu_rst=%b busy=%b ready=%b done=%b error=%b expected 1 0 0 0 0",
               cpu_rst, busy, byte_ready, done, error);
    end
    load_good_image();
    run_image("after_mid_reset", 0);
  endtask

  task automatic test_empty();
    img_q = '{8'h00, 8'h00, 8'h00};
    run_image("empty", 0);
  endtask

  task automatic test_restart_from_done();
    load_good_image();
    run_image("pre_restart", 0);
    pulse_start();
    n_checks++;
    if ({cpu_rst, busy, done, error, byte_ready} !== 5'b11001) begin
      n_fail++;
      $display("FAIL restart_from_done: got cpu_rst=%b busy=%b done=%b error=%b ready=%b expected 1 1 0 0 1",
               cpu_rst, busy, done, error, byte_ready);
    end
    // Finish the load that was just started so the next test starts from DONE.
    for (int i = 0; i < n_send; i++) send_byte(img_q[i], 0);
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_complete: got done=%b expected 1", done);
    end
  endtask

  task automatic test_start_while_busy();
    load_good_image();
    build_model();
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < n_send; i++) begin
      send_byte(img_q[i], 0);
      if (i == 4) begin
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || wr_q.size() != 2) begin
      n_fail++;
      $display("FAIL start_while_busy: got done=%b writes=%0d expected done=1 writes=2", done, wr_q.size());
    end
  endtask

  task automatic test_random();
    int len, r;
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) len = 0;
      else if (r == 1) len = DEPTH + $urandom_range(1, 3);
      else len = $urandom_range(1, 6);
      make_random_image(len, ($urandom_range(0, 3) == 0));
      run_image($sformatf("random_%0d_len%0d", n, len), 2);
    end
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_throttled();
    test_bad_csum();
    test_overflow();
    test_len_depth();
    test_reset_mid_load();
    test_empty();
    test_restart_from_done();
    test_start_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
